rd_skew_control: RTL and testbench
==================================

Name: rd_skew_control

Overview:
Read-side sequencer for the systolic array. It sits upstream of the array and produces per-lane read enables and per-lane read address offsets into the input memory banks. Lane i is a copy of lane 0 delayed by i cycles, which supplies the diagonal data skew the array needs. It runs one burst per start request and reports completion with a done pulse, so the top-level controller can start the array and the write-side sequencer.

Parameters:
width_height, 4, number of array lanes (rows) and memory banks
addr_width, 8, width of one lane's address

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
start  input  1  request a burst; sampled only in IDLE
base_addr  input  addr_width  first address of the burst; latched when start is accepted
num_rows  input  addr_width  vectors per lane (N); latched when start is accepted
stall  input  1  freeze the sequence while high
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle completion pulse
rd_en  output  width_height  per-lane read enable; bit i is lane i
rd_addr  output  width_height*addr_width  per-lane address; lane i occupies bits [i*addr_width +: addr_width]

Behaviour:
- All outputs are registered.
- Reset: reset==0 at a clock edge forces IDLE, clears the counter and latched values, and sets busy=0, done=0, rd_en=0, rd_addr=0 from the next cycle. This applies mid-burst as well.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 with N>0: latch base_addr and N, set c=0, go to RUN.
  - start=1 with N==0: go to DONE with no enables issued.
  - start=0: stay in IDLE.
- RUN:
  - Outputs for step c appear in the cycle after that step's edge. The first RUN cycle shows c=0.
  - rd_en[i] = (c >= i) && (c - i < N).
  - Lane i address = base + (c - i) mod 2^addr_width when rd_en[i]=1. Otherwise the lane address is 0.
  - c advances by 1 on each edge where stall=0.
  - When the step c = N + width_height - 2 has been issued, the next edge goes to DONE.
  - Burst length is N + width_height - 1 unstalled cycles.
- Counter width: addr_width + $clog2(width_height) + 1 bits, so the counter does not overflow for N = 2^addr_width - 1.
- stall:
  - While stall=1 in RUN, rd_en is forced to 0, rd_addr holds its last value, c holds, and busy stays 1.
  - Deasserting stall resumes at the held c, with no step skipped or repeated.
  - stall has no effect in IDLE or DONE.
- DONE: done=1 and busy=0 for exactly one cycle, rd_en=0, then go to IDLE. A new start is accepted in the cycle after done.
- start while in RUN or DONE is ignored and not queued.
- busy=1 exactly while in RUN.
- Address arithmetic wraps modulo 2^addr_width with no error flag.

Decomposition:
- Shared package tpu_ctrl_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a lane-address slice helper;
  - the default width_height and addr_width constants, so the write-side sequencer uses the same values.
- One sub-module, rd_lane_gen, is instantiated per lane with a generate loop. Inputs: c, N, base, lane index i. Outputs: that lane's rd_en bit and address, from a comparison and an add. The top module holds the FSM, the counter and the output registers.

Test Plan:
(All cases use width_height=4, addr_width=8.)
1. Hold reset=0 for 2 cycles while start=1 -> busy=0, done=0, rd_en=0000, rd_addr=0 throughout. No burst starts after reset is released until a new start.
2. start with base=0x10, N=3 -> six cycles of rd_en: 0001, 0011, 0111, 1110, 1100, 1000.
   - Cycle 1: lane0=0x10.
   - Cycle 3: lane0=0x12, lane1=0x11, lane2=0x10.
   - Cycle 4: lane3=0x10.
   - Cycle 6: lane3=0x12.
   - Cycle 7: done=1, busy=0.
3. start with base=0xFE, N=3 -> lane0 issues 0xFE, 0xFF, 0x00 on consecutive cycles, and lane3 issues the same three addresses 3 cycles later.
4. Same burst as case 2, with stall=1 for 2 cycles starting at burst cycle 3 -> rd_en=0000 and rd_addr held during the stall. Cycle 3's pattern (0111 with lanes 0x12/0x11/0x10) reappears afterward. done is 2 cycles late, at cycle 9.
5. start with N=0 -> done pulses the next cycle, busy never rises, rd_en stays 0. A second start pulse during a case-2 burst is ignored, and only one done is produced.
6. Drive reset=0 at burst cycle 3 of case 2 -> next cycle all outputs are 0 and the state is IDLE. A new start then runs a full clean burst from c=0.

Source files
------------

// File: rtl/tpu_ctrl_pkg.sv
// Shared definitions for the systolic-array read/write sequencers.
package tpu_ctrl_pkg;

  localparam int DEFAULT_WIDTH_HEIGHT = 4;
  localparam int DEFAULT_ADDR_WIDTH   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit offset of a lane's address field inside the packed address bus.
  function automatic int lane_lsb(input int lane, input int aw);
    return lane * aw;
  endfunction

endpackage

// File: rtl/rd_skew_control_if.sv
// Start/stall request side and per-lane read outputs of the read sequencer.
interface rd_skew_control_if
  import tpu_ctrl_pkg::*;
#(
  parameter int width_height = DEFAULT_WIDTH_HEIGHT,
  parameter int addr_width   = DEFAULT_ADDR_WIDTH
);

  logic                               start;
  logic [addr_width-1:0]              base_addr;
  logic [addr_width-1:0]              num_rows;
  logic                               stall;
  logic                               busy;
  logic                               done;
  logic [width_height-1:0]            rd_en;
  logic [width_height*addr_width-1:0] rd_addr;

  modport master (
    output start, base_addr, num_rows, stall,
    input  busy, done, rd_en, rd_addr
  );

  modport slave (
    input  start, base_addr, num_rows, stall,
    output busy, done, rd_en, rd_addr
  );

endinterface

// File: rtl/rd_lane_gen.sv
// One lane of the skewed read pattern: lane LANE trails lane 0 by LANE steps.
module rd_lane_gen #(
  parameter int addr_width = 8,
  parameter int cnt_width  = 11,
  parameter int LANE       = 0
) (
  input  logic [cnt_width-1:0]  c,
  input  logic [addr_width-1:0] n,
  input  logic [addr_width-1:0] base,
  output logic                  rd_en,
  output logic [addr_width-1:0] rd_addr
);

  logic [cnt_width-1:0] diff;
  logic                 en;

  // Lane is active once the step has reached it and until N vectors have gone by.
  always_comb begin
    diff    = c - cnt_width'(LANE);
    en      = (c >= cnt_width'(LANE)) && (diff < cnt_width'(n));
    rd_en   = en;
    rd_addr = en ? (base + diff[addr_width-1:0]) : '0;
  end

endmodule

// File: rtl/rd_skew_control.sv
// Read-side sequencer: issues one skewed burst of per-lane reads per start.
module rd_skew_control
  import tpu_ctrl_pkg::*;
#(
  parameter int width_height = DEFAULT_WIDTH_HEIGHT,
  parameter int addr_width   = DEFAULT_ADDR_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  rd_skew_control_if.slave   bus
);

  // Wide enough that N + width_height - 2 never overflows for the largest N.
  localparam int CW = addr_width + $clog2(width_height) + 1;

  state_e                             state_q, state_d;
  logic [CW-1:0]                      c_q, c_d;
  logic [addr_width-1:0]              n_q, n_d;
  logic [addr_width-1:0]              base_q, base_d;
  logic                               busy_q, busy_d;
  logic                               done_q, done_d;
  logic [width_height-1:0]            rd_en_q, rd_en_d;
  logic [width_height*addr_width-1:0] rd_addr_q, rd_addr_d;

  logic [CW-1:0]                      lane_c;
  logic [addr_width-1:0]              lane_n;
  logic [addr_width-1:0]              lane_base;
  logic [width_height-1:0]            lane_en;
  logic [width_height*addr_width-1:0] lane_addr;
  logic [CW-1:0]                      last_step;

  // Lanes evaluate the step about to be registered: step 0 of a new burst in
  // IDLE (from the live inputs), otherwise the step after the one on display.
  always_comb begin
    if (state_q == IDLE) begin
      lane_c    = '0;
      lane_n    = bus.num_rows;
      lane_base = bus.base_addr;
    end else begin
      lane_c    = c_q + CW'(1);
      lane_n    = n_q;
      lane_base = base_q;
    end
  end

  for (genvar i = 0; i < width_height; i++) begin : g_lane
    localparam int LSB = lane_lsb(i, addr_width);
    rd_lane_gen #(
      .addr_width (addr_width),
      .cnt_width  (CW),
      .LANE       (i)
    ) u_lane (
      .c       (lane_c),
      .n       (lane_n),
      .base    (lane_base),
      .rd_en   (lane_en[i]),
      .rd_addr (lane_addr[LSB +: addr_width])
    );
  end

  // Last step of the burst: lane width_height-1 issuing its final vector.
  always_comb begin
    last_step = CW'(n_q) + CW'(width_height - 2);
  end

  // Next-state, counter and registered-output values.
  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    n_d       = n_q;
    base_d    = base_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    rd_en_d   = '0;
    rd_addr_d = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          n_d    = bus.num_rows;
          base_d = bus.base_addr;
          c_d    = '0;
          if (bus.num_rows != '0) begin
            state_d   = RUN;
            busy_d    = 1'b1;
            rd_en_d   = lane_en;
            rd_addr_d = lane_addr;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.stall) begin
          busy_d    = 1'b1;
          rd_addr_d = rd_addr_q;
        end else if (c_q == last_step) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          c_d       = c_q + CW'(1);
          busy_d    = 1'b1;
          rd_en_d   = lane_en;
          rd_addr_d = lane_addr;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, latched burst parameters and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      c_q       <= '0;
      n_q       <= '0;
      base_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      n_q       <= n_d;
      base_q    <= base_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;

endmodule

// File: tb/tb_rd_skew_control.sv
// Bench for rd_skew_control: directed cases plus random bursts with stalls.
module tb_rd_skew_control;

  localparam int WH = 4;
  localparam int AW = 8;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  rd_skew_control_if #(.width_height(WH), .addr_width(AW)) bus ();

  rd_skew_control #(.width_height(WH), .addr_width(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected lane pattern for burst step c, straight from the skew rule.
  function automatic void lanes(input logic [7:0] b, input logic [7:0] n, input int c,
                                output logic [WH-1:0] en, output logic [WH*AW-1:0] a);
    en = '0;
    a  = '0;
    for (int i = 0; i < WH; i++) begin
      if (c >= i && (c - i) < int'(n)) begin
        en[i]        = 1'b1;
        a[i*AW +: AW] = b + 8'(c - i);
      end
    end
  endfunction

  task automatic chk(input string tag, input logic eb, input logic ed,
                     input logic [WH-1:0] een, input logic [WH*AW-1:0] ea, input bit use_addr);
    vectors++;
    assert (bus.busy === eb) else begin
      miscompares++;
      $error("FAIL %s busy: got %b want %b", tag, bus.busy, eb);
    end
    vectors++;
    assert (bus.done === ed) else begin
      miscompares++;
      $error("FAIL %s done: got %b want %b", tag, bus.done, ed);
    end
    vectors++;
    assert (bus.rd_en === een) else begin
      miscompares++;
      $error("FAIL %s rd_en: got %b want %b", tag, bus.rd_en, een);
    end
    if (use_addr) begin
      vectors++;
      assert (bus.rd_addr === ea) else begin
        miscompares++;
        $error("FAIL %s rd_addr: got %h want %h", tag, bus.rd_addr, ea);
      end
    end
  endtask

  // Runs one burst from IDLE. Output after edge Ek (k>=1) shows step = number
  // of unstalled edges among E1..Ek; a stalled edge shows no enables and the
  // previous addresses; the first unstalled edge past the last step is done.
  task automatic burst(input logic [7:0] b, input logic [7:0] n, input logic [63:0] smask,
                       input int dup_at, input bit dup_done, output int done_cyc);
    logic [WH-1:0]    een;
    logic [WH*AW-1:0] ea, prev;
    int  step, last;
    bit  s;
    done_cyc = -1;
    bus.start = 1'b1; bus.base_addr = b; bus.num_rows = n; bus.stall = smask[0];
    @(negedge clk);
    bus.start = 1'b0; bus.base_addr = 8'($urandom); bus.num_rows = 8'($urandom);
    if (n == 8'd0) begin
      chk("zero_n", 1'b0, 1'b1, '0, '0, 1'b0);
      done_cyc = 1;
    end else begin
      last = int'(n) + WH - 2;
      step = 0;
      lanes(b, n, 0, een, ea);
      chk("run", 1'b1, 1'b0, een, ea, 1'b1);
      prev = ea;
      for (int k = 1; k < 600; k++) begin
        s = smask[k % 64];
        bus.stall = s;
        bus.start = (k == dup_at);
        @(negedge clk);
        if (s) begin
          chk("stall", 1'b1, 1'b0, '0, prev, 1'b1);
        end else begin
          step++;
          if (step > last) begin
            chk("done", 1'b0, 1'b1, '0, '0, 1'b0);
            done_cyc = k + 1;
            break;
          end
          lanes(b, n, step, een, ea);
          chk("run", 1'b1, 1'b0, een, ea, 1'b1);
          prev = ea;
        end
      end
    end
    bus.stall = 1'($urandom_range(0, 1));
    bus.start = dup_done;
    @(negedge clk);
    chk("after_done", 1'b0, 1'b0, '0, '0, 1'b0);
    bus.start = 1'b0;
    bus.stall = 1'b0;
  endtask

  initial begin
    logic [WH-1:0]    een;
    logic [WH*AW-1:0] ea;
    int dc;
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    bus.start = 1'b1; bus.base_addr = 8'h10; bus.num_rows = 8'd3; bus.stall = 1'b0;

    // Reset held low with start asserted.
    @(negedge clk); chk("reset0", 1'b0, 1'b0, '0, '0, 1'b1);
    @(negedge clk); chk("reset1", 1'b0, 1'b0, '0, '0, 1'b1);
    reset = 1'b1; bus.start = 1'b0;
    @(negedge clk); chk("post_reset0", 1'b0, 1'b0, '0, '0, 1'b1);
    @(negedge clk); chk("post_reset1", 1'b0, 1'b0, '0, '0, 1'b1);

    // Basic burst, wrap burst, stalled burst.
    burst(8'h10, 8'd3, 64'h0, -1, 1'b0, dc);
    vectors++;
    assert (dc === 7) else begin miscompares++; $error("FAIL basic_done_cycle: got %0d want 7", dc); end
    burst(8'hFE, 8'd3, 64'h0, -1, 1'b0, dc);
    burst(8'h10, 8'd3, 64'hC, -1, 1'b0, dc);
    vectors++;
    assert (dc === 9) else begin miscompares++; $error("FAIL stall_done_cycle: got %0d want 9", dc); end

    // N==0 and a start pulse during a running burst / during done.
    burst(8'h33, 8'd0, 64'h0, -1, 1'b1, dc);
    burst(8'h10, 8'd3, 64'h0, 2, 1'b1, dc);
    vectors++;
    assert (dc === 7) else begin miscompares++; $error("FAIL dup_start_done_cycle: got %0d want 7", dc); end

    // Reset in the middle of a burst.
    bus.start = 1'b1; bus.base_addr = 8'h10; bus.num_rows = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      lanes(8'h10, 8'd3, c, een, ea);
      chk("pre_mid_reset", 1'b1, 1'b0, een, ea, 1'b1);
    end
    reset = 1'b0;
    @(negedge clk); chk("mid_reset", 1'b0, 1'b0, '0, '0, 1'b1);
    reset = 1'b1;
    @(negedge clk); chk("mid_reset_idle", 1'b0, 1'b0, '0, '0, 1'b1);
    burst(8'h10, 8'd3, 64'h0, -1, 1'b0, dc);
    vectors++;
    assert (dc === 7) else begin miscompares++; $error("FAIL post_reset_done_cycle: got %0d want 7", dc); end

    // Longest legal burst, with wrapping addresses.
    burst(8'hF0, 8'hFF, 64'h0, 100, 1'b1, dc);
    vectors++;
    assert (dc === 259) else begin miscompares++; $error("FAIL long_done_cycle: got %0d want 259", dc); end

    // Random bursts with random stalls and stray start pulses.
    for (int r = 0; r < 40; r++) begin
      logic [63:0] m;
      m = {$urandom, $urandom} & {$urandom, $urandom};
      burst(8'($urandom), 8'($urandom_range(0, 12)), m, int'($urandom_range(1, 20)),
            1'($urandom_range(0, 1)), dc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
